// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory stage: MMIO map, access sizes, LDX selects.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // Memory-mapped I/O addresses (region selected by addr[31]=1)
    localparam logic [31:0] MMIO_UART_STAT = 32'h8000_0000;
    localparam logic [31:0] MMIO_UART_RX   = 32'h8000_0004;
    localparam logic [31:0] MMIO_UART_TX   = 32'h8000_0008;
    localparam logic [31:0] MMIO_CYCLE     = 32'h8000_0010;
    localparam logic [31:0] MMIO_INSTR     = 32'h8000_0014;
    localparam logic [31:0] MMIO_CNT_CLR   = 32'h8000_0018;

    // mem_size encodings; 2'b11 behaves as a word access
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Load extractor select encodings
    typedef enum logic [2:0] {
        LDX_LW  = 3'b000,
        LDX_LHU = 3'b001,
        LDX_LH  = 3'b010,
        LDX_LBU = 3'b011,
        LDX_LB  = 3'b100
    } ldx_sel_e;

    function automatic ldx_sel_e ldx_sel_of(input logic [1:0] size, input logic is_unsigned);
        case (size)
            SIZE_BYTE: return is_unsigned ? LDX_LBU : LDX_LB;
            SIZE_HALF: return is_unsigned ? LDX_LHU : LDX_LH;
            default:   return LDX_LW;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_counters.sv
// Free-running cycle counter and retired-instruction counter, readable over MMIO.
// Latency: increment/clear visible the cycle after the request.
// Backpressure: none; clear wins over increment, both wrap at 2^32.
module mmio_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inst_inc,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    // Count cycles unconditionally and instructions on request; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_inc) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage front-end: BRAM and MMIO (UART, counters) access, load metadata for LDX.
// Latency: access in cycle N, ldx_* outputs valid in N+1; stall freezes all metadata.
// Backpressure: stall suppresses side effects; UART TX bytes are dropped if not ready.
// Optional: define MISALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DMEM_AWIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   inst_valid,
    input  logic                   mem_rd,
    input  logic                   mem_wr,
    input  logic [1:0]             mem_size,
    input  logic                   mem_unsigned,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   dmem_en,
    output logic [3:0]             dmem_we,
    output logic [DMEM_AWIDTH-1:0] dmem_addr,
    output logic [31:0]            dmem_din,
    input  logic [31:0]            dmem_dout,
    input  logic                   uart_tx_ready,
    output logic                   uart_tx_valid,
    output logic [7:0]             uart_tx_data,
    input  logic                   uart_rx_valid,
    input  logic [7:0]             uart_rx_data,
    output logic                   uart_rx_ready,
    output logic [31:0]            ldx_in,
    output logic [2:0]             ldx_sel,
    output logic [1:0]             ldx_offset,
    output logic                   misaligned
);

    logic        act;
    logic        ok;
    logic        is_mmio;
    logic        load_req;
    logic        mis_c;
    logic        cnt_clr;
    logic [3:0]  we_raw;
    logic [31:0] mmio_rdata;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    ldx_sel_e    ldx_sel_q;
    logic [1:0]  offset_q;
    logic        src_q;
    logic        bram_q;
    logic [31:0] mmio_q;
    logic        mis_q;

    assign act      = !stall && !rst;
    assign is_mmio  = addr[31];
    // A simultaneous store wins; the load side is treated as absent
    assign load_req = mem_rd && !mem_wr;

    // Misalignment detection (half at odd offset, word at any nonzero offset)
    always_comb begin
        mis_c = 1'b0;
`ifdef MISALIGN_CHECK_EN
        case (mem_size)
            SIZE_BYTE: mis_c = 1'b0;
            SIZE_HALF: mis_c = addr[0];
            default:   mis_c = (addr[1:0] != 2'b00);
        endcase
`endif
    end

    assign ok = act && !mis_c;

    // Lane replication and byte enables for stores
    always_comb begin
        we_raw   = 4'b1111;
        dmem_din = wdata;
        case (mem_size)
            SIZE_BYTE: begin
                we_raw   = 4'b0001 << addr[1:0];
                dmem_din = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                we_raw   = 4'b0011 << addr[1:0];
                dmem_din = {2{wdata[15:0]}};
            end
            default: begin
                we_raw   = 4'b1111;
                dmem_din = wdata;
            end
        endcase
    end

    assign dmem_en       = !stall;
    assign dmem_addr     = addr[DMEM_AWIDTH+1:2];
    assign dmem_we       = (mem_wr && ok && !is_mmio) ? we_raw : 4'b0000;
    assign uart_tx_valid = mem_wr && ok && (addr == MMIO_UART_TX);
    assign uart_tx_data  = wdata[7:0];
    assign uart_rx_ready = load_req && ok && (addr == MMIO_UART_RX);
    assign cnt_clr       = mem_wr && ok && (addr == MMIO_CNT_CLR);

    // MMIO read mux; unmapped addresses read as zero
    always_comb begin
        mmio_rdata = 32'd0;
        case (addr)
            MMIO_UART_STAT: mmio_rdata = {30'd0, uart_rx_valid, uart_tx_ready};
            MMIO_UART_RX:   mmio_rdata = {24'd0, uart_rx_data};
            MMIO_CYCLE:     mmio_rdata = cycle_cnt;
            MMIO_INSTR:     mmio_rdata = instr_cnt;
            default:        mmio_rdata = 32'd0;
        endcase
    end

    mmio_counters u_counters (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .inst_inc  (inst_valid && !stall),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    // Load metadata crossing the BRAM read latency; held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            ldx_sel_q <= LDX_LW;
            offset_q  <= 2'b00;
            src_q     <= 1'b0;
            bram_q    <= 1'b0;
            mmio_q    <= 32'd0;
            mis_q     <= 1'b0;
        end else begin
            // One-cycle flag aligned with the ldx outputs of the offending access
            mis_q <= mis_c && (mem_rd || mem_wr) && !stall;
            if (!stall) begin
                ldx_sel_q <= load_req ? ldx_sel_of(mem_size, mem_unsigned) : LDX_LW;
                offset_q  <= addr[1:0];
                src_q     <= load_req && is_mmio;
                bram_q    <= load_req && !is_mmio;
                mmio_q    <= (load_req && is_mmio) ? mmio_rdata : 32'd0;
            end
        end
    end

    // BRAM data is forwarded only after a BRAM load, so reset and non-load cycles read zero
    assign ldx_in     = src_q ? mmio_q : (bram_q ? dmem_dout : 32'd0);
    assign ldx_sel    = ldx_sel_q;
    assign ldx_offset = offset_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small BRAM model.
// Latency: drives one access per cycle, checks ldx outputs one edge later.
// Backpressure: exercises stall and uart_tx_ready=0/1 paths.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        inst_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic        uart_tx_ready;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic [31:0] ldx_in;
    logic [2:0]  ldx_sel;
    logic [1:0]  ldx_offset;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    mem_access_unit #(.DMEM_AWIDTH(14)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .inst_valid    (inst_valid),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .dmem_en       (dmem_en),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_din      (dmem_din),
        .dmem_dout     (dmem_dout),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .ldx_in        (ldx_in),
        .ldx_sel       (ldx_sel),
        .ldx_offset    (ldx_offset),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    // Read-before-write BRAM model, one cycle read latency
    always @(posedge clk) begin
        if (dmem_en) begin
            dmem_dout <= mem[dmem_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (dmem_we[b]) mem[dmem_addr[7:0]][b*8 +: 8] <= dmem_din[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic iv);
        mem_rd       = rd;
        mem_wr       = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
        inst_valid   = iv;
        #1;
    endtask

    task automatic idle(input logic iv);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, iv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load select table: size, unsigned, address, expected select
    logic [1:0]  ld_size [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
    logic        ld_uns  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ld_addr [6] = '{32'h202, 32'h202, 32'h203, 32'h201, 32'h200, 32'h200};
    logic [2:0]  ld_sel  [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b000, 3'b000};

    int rx_pulses;
    int tx_pulses;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        dmem_dout     = 32'h0;
        rst           = 1'b1;
        stall         = 1'b0;
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;

        // Reset: no strobes while rst is high, all registered outputs zero
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'h41, 1'b1);
        chk("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h55, 1'b1);
        chk("rst_dmem_we", {28'd0, dmem_we}, 32'd0);
        repeat (3) step();
        chk("rst_ldx_sel", {29'd0, ldx_sel}, 32'd0);
        chk("rst_ldx_off", {30'd0, ldx_offset}, 32'd0);
        chk("rst_ldx_in", ldx_in, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        rst = 1'b0;

        // sb at offset 3
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 1'b1);
        chk("sb_we", {28'd0, dmem_we}, 32'h8);
        chk("sb_din", dmem_din, 32'hABAB_ABAB);
        chk("sb_addr", {18'd0, dmem_addr}, 32'h40);
        step();

        // sh at offset 2
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h0000_BEEF, 1'b1);
        chk("sh_we", {28'd0, dmem_we}, 32'hC);
        chk("sh_din", dmem_din, 32'hBEEF_BEEF);
        step();

        // sw then loads of every width from the same word
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h8001_1234, 1'b1);
        chk("sw_we", {28'd0, dmem_we}, 32'hF);
        chk("sw_din", dmem_din, 32'h8001_1234);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, ld_size[i], ld_uns[i], ld_addr[i], 32'h0, 1'b1);
            chk("ld_no_we", {28'd0, dmem_we}, 32'd0);
            step();
            chk($sformatf("ld%0d_sel", i), {29'd0, ldx_sel}, {29'd0, ld_sel[i]});
            chk($sformatf("ld%0d_off", i), {30'd0, ldx_offset}, {30'd0, ld_addr[i][1:0]});
            chk($sformatf("ld%0d_in", i), ldx_in, 32'h8001_1234);
        end
        idle(1'b1);
        step();
        chk("nonload_sel", {29'd0, ldx_sel}, 32'd0);

        // UART TX strobe, then the same store under stall
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'h0000_0041, 1'b1);
        chk("tx_valid", {31'd0, uart_tx_valid}, 32'd1);
        chk("tx_data", {24'd0, uart_tx_data}, 32'h41);
        chk("tx_no_we", {28'd0, dmem_we}, 32'd0);
        step();
        idle(1'b1);
        chk("tx_one_cycle", {31'd0, uart_tx_valid}, 32'd0);
        stall = 1'b1;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'h0000_0041, 1'b1);
        chk("tx_stall_valid", {31'd0, uart_tx_valid}, 32'd0);
        chk("stall_dmem_en", {31'd0, dmem_en}, 32'd0);
        step();
        stall = 1'b0;

        // Dropped byte: strobe still issued with uart_tx_ready low
        uart_tx_ready = 1'b0;
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0008, 32'h0000_0042, 1'b1);
        chk("tx_notready_valid", {31'd0, uart_tx_valid}, 32'd1);
        step();

        // Status register
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b1;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
        step();
        chk("uart_status", ldx_in, 32'h3);

        // Unmapped MMIO: write ignored, read returns zero
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_000C, 32'h0000_0077, 1'b1);
        chk("unmapped_wr_we", {28'd0, dmem_we}, 32'd0);
        chk("unmapped_wr_tx", {31'd0, uart_tx_valid}, 32'd0);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0, 1'b1);
        step();
        chk("unmapped_rd", ldx_in, 32'd0);

        // RX load followed by a 3-cycle stall holding the instruction
        uart_rx_data = 8'h5A;
        rx_pulses = 0;
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h8000_0004, 32'h0, 1'b1);
        if (uart_rx_ready) rx_pulses++;
        step();
        chk("rx_ldx_in", ldx_in, 32'h0000_005A);
        stall = 1'b1;
        uart_rx_data = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (uart_rx_ready) rx_pulses++;
            step();
            chk($sformatf("rx_stall%0d_in", i), ldx_in, 32'h0000_005A);
        end
        stall = 1'b0;
        idle(1'b1);
        chk("rx_pulses", rx_pulses, 32'd1);
        uart_rx_valid = 1'b0;
        step();

        // Counters: clear, 100 cycles with 40 instructions, read both
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0018, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 100; i++) begin
            idle(i < 40);
            step();
        end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0014, 32'h0, 1'b0);
        step();
        chk("instr_cnt_40", ldx_in, 32'd40);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
        step();
        chk("cycle_cnt_101", ldx_in, 32'd101);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0018, 32'h0, 1'b1);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 1'b1);
        step();
        chk("cycle_after_clr", ldx_in, 32'd0);
        idle(1'b1);
        step();
        idle(1'b1);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0014, 32'h0, 1'b1);
        step();
        chk("instr_after_clr", ldx_in, 32'd3);

        // Stalled instruction does not count
        stall = 1'b1;
        idle(1'b1);
        step();
        stall = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0014, 32'h0, 1'b0);
        step();
        chk("instr_stall_hold", ldx_in, 32'd4);

`ifdef MISALIGN_CHECK_EN
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1234_5678, 1'b1);
        chk("mis_sw_we", {28'd0, dmem_we}, 32'd0);
        step();
        idle(1'b1);
        chk("mis_flag_n1", {31'd0, misaligned}, 32'd1);
        step();
        chk("mis_flag_n2", {31'd0, misaligned}, 32'd0);
        tx_pulses = 0;
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0207, 32'h0000_BEEF, 1'b1);
        chk("mis_sh_we", {28'd0, dmem_we}, 32'd0);
        step();
        chk("mis_sh_flag", {31'd0, misaligned}, 32'd1);
`else
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0207, 32'h0000_BEEF, 1'b1);
        chk("sh_off3_we", {28'd0, dmem_we}, 32'h8);
        step();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1234_5678, 1'b1);
        chk("sw_off2_we", {28'd0, dmem_we}, 32'hF);
        step();
        chk("mis_tied0", {31'd0, misaligned}, 32'd0);
`endif

        // Reset in the middle of a load
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_no_rxrdy", {31'd0, uart_rx_ready}, 32'd0);
        step();
        chk("rst_mid_sel", {29'd0, ldx_sel}, 32'd0);
        chk("rst_mid_in", ldx_in, 32'd0);
        chk("rst_mid_off", {30'd0, ldx_offset}, 32'd0);
        rst = 1'b0;
        idle(1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage front-end of the RV32I pipeline.
- Turns execute-stage load/store requests into BRAM data-memory accesses and memory-mapped I/O accesses: UART and the cycle/instruction counters.
- Registers load metadata across the 1-cycle BRAM read latency. Directly feeds the load extractor (LDX) with ldx_in, ldx_sel and the byte offset.

Parameters:
- DMEM_AWIDTH, 14, word-address width of data BRAM (2^14 words = 64 KiB).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline hold; suppresses all side effects, freezes metadata
- inst_valid  in  1  a real instruction occupies this stage (counter increment)
- mem_rd  in  1  load request
- mem_wr  in  1  store request
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_unsigned  in  1  zero-extend load (lbu/lhu)
- addr  in  32  effective address from ALU
- wdata  in  32  store data (rs2)
- dmem_en  out  1  BRAM enable
- dmem_we  out  4  BRAM byte write enables
- dmem_addr  out  DMEM_AWIDTH  BRAM word address = addr[DMEM_AWIDTH+1:2]
- dmem_din  out  32  lane-replicated store data
- dmem_dout  in  32  BRAM read data, valid one cycle after the access
- uart_tx_ready  in  1  UART transmitter can accept
- uart_tx_valid  out  1  UART TX byte strobe
- uart_tx_data  out  8  UART TX byte
- uart_rx_valid  in  1  UART holds a received byte
- uart_rx_data  in  8  received byte
- uart_rx_ready  out  1  RX byte consumed
- ldx_in  out  32  raw word to LDX
- ldx_sel  out  3  LDX select: 000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb
- ldx_offset  out  2  registered addr[1:0] to LDX
- misaligned  out  1  misaligned-access flag (optional feature)

Behaviour:
- Region decode:
  - addr[31]=0 → BRAM.
  - addr[31]=1 → MMIO. Unmapped MMIO reads return 0; unmapped MMIO writes are ignored.
- MMIO map:
  - 0x80000000 R: {30'b0, uart_rx_valid, uart_tx_ready}
  - 0x80000004 R: {24'b0, uart_rx_data}
  - 0x80000008 W: TX byte
  - 0x80000010 R: cycle_cnt
  - 0x80000014 R: instr_cnt
  - 0x80000018 W: clear both counters
- Access qualifier: act = !stall & !rst. All strobes below are gated by act.
- dmem_en = !stall.
- Store byte enables (BRAM region only, mem_wr & act):
  - sb: we = 4'b0001 << addr[1:0], din = {4{wdata[7:0]}}
  - sh: we = (4'b0011 << addr[1:0]) truncated to 4 bits, din = {2{wdata[15:0]}}
  - sw: we = 4'b1111, din = wdata
  - Otherwise we = 0.
- UART TX: uart_tx_valid = mem_wr & act & hit(0x80000008); uart_tx_data = wdata[7:0].
  - Issued even if uart_tx_ready=0; the byte is then dropped. Software polls the status register.
- UART RX: uart_rx_ready = mem_rd & act & hit(0x80000004). One-cycle pulse per load.
- Load latency: access in cycle N → ldx_in/ldx_sel/ldx_offset valid in cycle N+1.
  - Registered on !stall: ldx_sel_q, offset_q = addr[1:0], src_q (1 = MMIO), mmio_q (MMIO read data sampled in cycle N).
  - ldx_in = src_q ? mmio_q : dmem_dout.
  - ldx_sel mapping: word→000, half→{unsigned ? 001 : 010}, byte→{unsigned ? 011 : 100}.
  - Non-load cycles register ldx_sel_q=000 and src_q=0.
- Stall: all registered metadata holds. The BRAM is disabled, so dmem_dout holds the previous read. ldx_in is stable throughout.
- Counters:
  - cycle_cnt increments every cycle after reset.
  - instr_cnt increments when inst_valid & !stall.
  - Both wrap at 2^32.
  - Clear store (act) wins over increment: both counters read 0 on the following cycle.
- Reset (synchronous, including mid-access): all outputs and registers are 0 at the edge after rst is sampled. This includes counters, ldx_sel_q, offset_q, src_q, mmio_q and misaligned. No strobes are issued while rst=1.
- Simultaneous mem_rd & mem_wr: illegal from decode; the store takes priority and the load metadata registers as a non-load.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Half access at offset 1 or 3, or word access at offset ≠0, is misaligned.
  - Misaligned accesses suppress dmem_we, uart_tx_valid, uart_rx_ready and counter clear.
  - misaligned is registered high for exactly the N+1 cycle, aligned with the ldx outputs.
- Undefined:
  - misaligned is tied 0.
  - Accesses proceed as computed, e.g. sh at offset 3 gives we = 4'b1000.

Decomposition:
- Shared defines header alongside the existing OPC_ macros:
  - MMIO address constants
  - mem_size encodings
  - LDX select encodings
- One sub-module, mmio_counters: cycle_cnt/instr_cnt with increment and clear inputs.

Test Plan:
- sb addr=0x00000103 wdata=0x000000AB → dmem_we=4'b1000, dmem_din=0xABABABAB, dmem_addr=0x40.
- lh addr=0x00000202, BRAM word 0x8001_1234, mem_unsigned=0 → next cycle ldx_sel=010, ldx_offset=2, ldx_in=0x80011234.
- uart_tx_ready=1, sw 0x80000008 wdata=0x41 → uart_tx_valid=1 for 1 cycle, uart_tx_data=0x41, dmem_we=0. Repeat with stall=1 → no strobe.
- Run 100 cycles, 40 with inst_valid, then sw 0x80000018 → cycle_cnt and instr_cnt read 0 the next cycle. Load 0x80000014 after 3 more valid instrs → ldx_in=3.
- Assert stall for 3 cycles after a load of 0x80000004 (rx_data=0x5A) → uart_rx_ready pulses once (pre-stall), ldx_in stays 0x0000005A throughout.
- With MISALIGN_CHECK_EN: sw addr=0x00000006 → dmem_we=0, misaligned=1 next cycle only. rst mid-load → ldx_sel=000, ldx_in=0 after the edge.
